axi_slave_ram: RTL and testbench

Synthesizable burst slave that terminates the lab's simplified AXI-style master interface: write-address, write-data (ID echoed on WR_BACK_ID), read-address and read-data channels.
Backs the bus with an internal single-clock, dual-port word RAM so simulation masters and on-chip masters have a real target.
Sits directly downstream of the master stage. Replaces ad-hoc memory models in the AXI4 testbenches and serves as a scratch RAM slave behind the interconnect.

---
 rtl/axi_sim_pkg.sv | 33 +++
 rtl/axi_ram_dp.sv | 58 +++++
 rtl/axi_slave_ram.sv | 167 ++++++++++++++++
 tb/tb_axi_slave_ram.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/axi_sim_pkg.sv
// Shared types for the simplified AXI-style burst slave.
// Holds the bus field widths, the write/read FSM state encodings and the
// per-burst context record used by both channel engines.
package axi_sim_pkg;

  localparam int ID_W   = 2;
  localparam int LEN_W  = 8;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_DATA = 1'b1
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_SEND  = 2'd2
  } rd_state_e;

  // Context latched on an address handshake; cnt counts accepted beats.
  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] cnt;
  } burst_t;

  function automatic logic burst_last(burst_t b);
    return b.cnt == b.len;
  endfunction

endpackage

// File: rtl/axi_ram_dp.sv
// Simple dual-port word RAM: one byte-enabled write port, one registered
// read port. Reads return the contents from before a same-cycle write.
// Ports:
//   clk          clock
//   rst          sync active-high; clears only the read output register
//   we/waddr/wdata/wstrb  write port, wstrb[i] enables wdata[8i+7:8i]
//   re/raddr     read request; rdata updates on the next edge when re=1
//   rdata        registered read data, held while re=0
module axi_ram_dp
  import axi_sim_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter bit INIT_ZERO  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [STRB_W-1:0]     wstrb,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_W-1:0]     rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Both branches share a name; only one exists after elaboration. The
  // array initialiser is a power-up value, so rst never touches contents.
  if (INIT_ZERO) begin : g_mem
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    always_ff @(posedge clk) begin
      if (we)
        for (int b = 0; b < STRB_W; b++)
          if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end

    always_ff @(posedge clk) begin
      if (rst)     rdata <= '0;
      else if (re) rdata <= mem[raddr];
    end
  end else begin : g_mem
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (we)
        for (int b = 0; b < STRB_W; b++)
          if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end

    always_ff @(posedge clk) begin
      if (rst)     rdata <= '0;
      else if (re) rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/axi_slave_ram.sv
// Burst RAM slave for the simplified AXI-style master interface.
// Independent write (W_IDLE/W_DATA) and read (R_IDLE/R_FETCH/R_SEND)
// engines share a dual-port word RAM; one burst in flight per direction.
// Ports:
//   clk, rst                   clock, sync active-high reset
//   WR_ADDR/LEN/ID/ADDR_VALID/ADDR_READY   write address channel
//   WR_DATA/STRB/DATA_VALID/DATA_READY/DATA_LAST, WR_BACK_ID  write data
//   RD_ADDR/LEN/ID/ADDR_VALID/ADDR_READY   read address channel
//   RD_DATA/DATA_LAST/BACK_ID/DATA_VALID/DATA_READY  read data channel
//   wr_len_err                 pulse: WR_DATA_LAST disagreed with beat count
module axi_slave_ram
  import axi_sim_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter bit INIT_ZERO  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       WR_ADDR,
  input  logic [LEN_W-1:0]  WR_LEN,
  input  logic [ID_W-1:0]   WR_ID,
  input  logic              WR_ADDR_VALID,
  output logic              WR_ADDR_READY,
  input  logic [DATA_W-1:0] WR_DATA,
  input  logic [STRB_W-1:0] WR_STRB,
  output logic [ID_W-1:0]   WR_BACK_ID,
  input  logic              WR_DATA_VALID,
  output logic              WR_DATA_READY,
  input  logic              WR_DATA_LAST,
  input  logic [31:0]       RD_ADDR,
  input  logic [LEN_W-1:0]  RD_LEN,
  input  logic [ID_W-1:0]   RD_ID,
  input  logic              RD_ADDR_VALID,
  output logic              RD_ADDR_READY,
  output logic [DATA_W-1:0] RD_DATA,
  output logic              RD_DATA_LAST,
  output logic [ID_W-1:0]   RD_BACK_ID,
  input  logic              RD_DATA_READY,
  output logic              RD_DATA_VALID,
  output logic              wr_len_err
);

  wr_state_e w_q, w_d;
  rd_state_e r_q, r_d;
  burst_t    wb, rb;
  logic [ADDR_WIDTH-1:0] wptr, rptr;
  logic ram_re;

  // Byte-offset and above-depth address bits carry no meaning here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{WR_ADDR[31:ADDR_WIDTH+2], WR_ADDR[1:0],
                              RD_ADDR[31:ADDR_WIDTH+2], RD_ADDR[1:0]};

  logic aw_hs, w_hs, ar_hs, r_hs;
  assign aw_hs = WR_ADDR_VALID & WR_ADDR_READY;
  assign w_hs  = WR_DATA_VALID & WR_DATA_READY;
  assign ar_hs = RD_ADDR_VALID & RD_ADDR_READY;
  assign r_hs  = RD_DATA_VALID & RD_DATA_READY;

  // ---------------- write engine ----------------
  always_comb begin
    w_d           = w_q;
    WR_ADDR_READY = 1'b0;
    WR_DATA_READY = 1'b0;
    case (w_q)
      W_IDLE: begin
        WR_ADDR_READY = 1'b1;
        if (WR_ADDR_VALID) w_d = W_DATA;
      end
      W_DATA: begin
        WR_DATA_READY = 1'b1;
        // Burst length comes from the latched len, never from LAST.
        if (WR_DATA_VALID && burst_last(wb)) w_d = W_IDLE;
      end
      default: w_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q        <= W_IDLE;
      wb         <= '0;
      wptr       <= '0;
      wr_len_err <= 1'b0;
    end else begin
      w_q        <= w_d;
      wr_len_err <= 1'b0;
      if (aw_hs) begin
        wb.id  <= WR_ID;
        wb.len <= WR_LEN;
        wb.cnt <= '0;
        wptr   <= WR_ADDR[ADDR_WIDTH+1:2];
      end
      if (w_hs) begin
        wb.cnt     <= wb.cnt + LEN_W'(1);
        wptr       <= wptr + ADDR_WIDTH'(1);  // wraps at RAM depth
        wr_len_err <= WR_DATA_LAST != burst_last(wb);
      end
    end
  end

  assign WR_BACK_ID = wb.id;

  // ---------------- read engine ----------------
  always_comb begin
    r_d           = r_q;
    RD_ADDR_READY = 1'b0;
    RD_DATA_VALID = 1'b0;
    ram_re        = 1'b0;
    case (r_q)
      R_IDLE: begin
        RD_ADDR_READY = 1'b1;
        if (RD_ADDR_VALID) r_d = R_FETCH;
      end
      R_FETCH: begin
        ram_re = 1'b1;
        r_d    = R_SEND;
      end
      R_SEND: begin
        RD_DATA_VALID = 1'b1;
        if (RD_DATA_READY) r_d = burst_last(rb) ? R_IDLE : R_FETCH;
      end
      default: r_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q  <= R_IDLE;
      rb   <= '0;
      rptr <= '0;
    end else begin
      r_q <= r_d;
      if (ar_hs) begin
        rb.id  <= RD_ID;
        rb.len <= RD_LEN;
        rb.cnt <= '0;
        rptr   <= RD_ADDR[ADDR_WIDTH+1:2];
      end
      if (r_hs && !burst_last(rb)) begin
        rb.cnt <= rb.cnt + LEN_W'(1);
        rptr   <= rptr + ADDR_WIDTH'(1);
      end
    end
  end

  assign RD_DATA_LAST = (r_q == R_SEND) && burst_last(rb);
  assign RD_BACK_ID   = rb.id;

  // RD_DATA is the RAM output register itself: it only loads in R_FETCH,
  // so it stays put for the whole R_SEND stall.
  axi_ram_dp #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_ZERO  (INIT_ZERO)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (w_hs),
    .waddr (wptr),
    .wdata (WR_DATA),
    .wstrb (WR_STRB),
    .re    (ram_re),
    .raddr (rptr),
    .rdata (RD_DATA)
  );

endmodule

// File: tb/tb_axi_slave_ram.sv
module tb_axi_slave_ram;

  localparam int AW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] WR_ADDR, WR_DATA, RD_ADDR, RD_DATA;
  logic [7:0]  WR_LEN, RD_LEN;
  logic [1:0]  WR_ID, WR_BACK_ID, RD_ID, RD_BACK_ID;
  logic [3:0]  WR_STRB;
  logic WR_ADDR_VALID, WR_ADDR_READY, WR_DATA_VALID, WR_DATA_READY, WR_DATA_LAST;
  logic RD_ADDR_VALID, RD_ADDR_READY, RD_DATA_LAST, RD_DATA_READY, RD_DATA_VALID;
  logic wr_len_err;

  always #5 clk = ~clk;

  axi_slave_ram #(.ADDR_WIDTH(AW), .INIT_ZERO(1'b1)) dut (
    .clk(clk), .rst(rst),
    .WR_ADDR(WR_ADDR), .WR_LEN(WR_LEN), .WR_ID(WR_ID),
    .WR_ADDR_VALID(WR_ADDR_VALID), .WR_ADDR_READY(WR_ADDR_READY),
    .WR_DATA(WR_DATA), .WR_STRB(WR_STRB), .WR_BACK_ID(WR_BACK_ID),
    .WR_DATA_VALID(WR_DATA_VALID), .WR_DATA_READY(WR_DATA_READY),
    .WR_DATA_LAST(WR_DATA_LAST),
    .RD_ADDR(RD_ADDR), .RD_LEN(RD_LEN), .RD_ID(RD_ID),
    .RD_ADDR_VALID(RD_ADDR_VALID), .RD_ADDR_READY(RD_ADDR_READY),
    .RD_DATA(RD_DATA), .RD_DATA_LAST(RD_DATA_LAST), .RD_BACK_ID(RD_BACK_ID),
    .RD_DATA_READY(RD_DATA_READY), .RD_DATA_VALID(RD_DATA_VALID),
    .wr_len_err(wr_len_err)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [1:0]  id;
  } rbeat_t;

  rbeat_t     rq[$];   // expected read beats
  logic [1:0] wq[$];   // expected WR_BACK_ID per write beat
  int n_chk = 0, n_fail = 0, rd_hs = 0, err_pulses = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: no handshake within 100 cycles", name);
  endtask

  function automatic rbeat_t mk(logic [31:0] d, logic l, logic [1:0] id);
    return {d, l, id};
  endfunction

  // Monitor / scoreboard: samples on the falling edge, away from the
  // active edge where inputs change (#1 after posedge).
  initial begin : mon
    rbeat_t cur, held, exp_b;
    logic   stall;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      cur = {RD_DATA, RD_DATA_LAST, RD_BACK_ID};
      if (rst) stall = 1'b0;
      else begin
        if (stall && RD_DATA_VALID) check("rd_hold", 64'(cur), 64'(held));
        stall = RD_DATA_VALID && !RD_DATA_READY;
        held  = cur;
        if (RD_DATA_VALID && RD_DATA_READY) begin
          rd_hs++;
          if (rq.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL rd_extra: unexpected beat %h", cur);
          end else begin
            exp_b = rq.pop_front();
            check("rd_beat", 64'(cur), 64'(exp_b));
          end
        end
        if (WR_DATA_VALID && WR_DATA_READY) begin
          check("wr_addr_ready_busy", 64'(WR_ADDR_READY), 64'(0));
          if (wq.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL wr_extra: unexpected write beat");
          end else check("wr_back_id", 64'(WR_BACK_ID), 64'(wq.pop_front()));
        end
        if (wr_len_err) err_pulses++;
      end
    end
  end

  // lmask[i] = WR_DATA_LAST driven on beat i; data of beat i = d0 + i.
  task automatic wr_burst(logic [31:0] addr, logic [7:0] len, logic [1:0] id,
                          logic [31:0] d0, logic [3:0] strb, logic [7:0] lmask);
    int n;
    @(posedge clk); #1;
    WR_ADDR = addr; WR_LEN = len; WR_ID = id; WR_ADDR_VALID = 1'b1;
    for (n = 0; n < 100; n++) begin @(negedge clk); if (WR_ADDR_READY) break; end
    @(posedge clk); #1;
    WR_ADDR_VALID = 1'b0;
    if (n == 100) begin timeout("wr_addr"); return; end
    for (int i = 0; i <= int'(len); i++) begin
      WR_DATA = d0 + 32'(i); WR_STRB = strb; WR_DATA_LAST = lmask[i];
      WR_DATA_VALID = 1'b1;
      wq.push_back(id);
      for (n = 0; n < 100; n++) begin @(negedge clk); if (WR_DATA_READY) break; end
      @(posedge clk); #1;
      if (n == 100) begin
        WR_DATA_VALID = 1'b0; WR_DATA_LAST = 1'b0; wq.delete();
        timeout("wr_data"); return;
      end
    end
    WR_DATA_VALID = 1'b0; WR_DATA_LAST = 1'b0;
    @(negedge clk);
    check("wr_addr_ready_after", 64'(WR_ADDR_READY), 64'(1));
  endtask

  // Expected beats are pushed into rq by the caller. rpat cycles on
  // RD_DATA_READY; abort pulses rst once the queued beats are consumed.
  task automatic rd_burst(logic [31:0] addr, logic [7:0] len, logic [1:0] id,
                          logic [3:0] rpat, bit abort);
    int n, k;
    @(posedge clk); #1;
    RD_ADDR = addr; RD_LEN = len; RD_ID = id; RD_ADDR_VALID = 1'b1;
    RD_DATA_READY = rpat[0];
    for (n = 0; n < 100; n++) begin @(negedge clk); if (RD_ADDR_READY) break; end
    @(posedge clk); #1;
    RD_ADDR_VALID = 1'b0;
    if (n == 100) begin timeout("rd_addr"); rq.delete(); return; end
    k = 0;
    while (rq.size() > 0 && k < 200) begin
      RD_DATA_READY = rpat[k % 4];
      @(posedge clk); #1;
      k++;
    end
    if (rq.size() > 0) begin timeout("rd_data"); rq.delete(); end
    RD_DATA_READY = 1'b0;
    if (abort) begin
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
    end
    @(negedge clk);
    check("rd_valid_idle", 64'(RD_DATA_VALID), 64'(0));
    check("rd_addr_ready_idle", 64'(RD_ADDR_READY), 64'(1));
  endtask

  initial begin : stim
    int h0, e0;
    rst = 1'b1;
    WR_ADDR = '0; WR_LEN = '0; WR_ID = '0; WR_ADDR_VALID = 1'b0;
    WR_DATA = '0; WR_STRB = '0; WR_DATA_VALID = 1'b0; WR_DATA_LAST = 1'b0;
    RD_ADDR = '0; RD_LEN = '0; RD_ID = '0; RD_ADDR_VALID = 1'b0;
    RD_DATA_READY = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wr_addr_ready", 64'(WR_ADDR_READY), 64'(1));
    check("rst_rd_addr_ready", 64'(RD_ADDR_READY), 64'(1));
    check("rst_wr_data_ready", 64'(WR_DATA_READY), 64'(0));
    check("rst_rd_data_valid", 64'(RD_DATA_VALID), 64'(0));
    check("rst_rd_data_last", 64'(RD_DATA_LAST), 64'(0));
    check("rst_rd_data", 64'(RD_DATA), 64'(0));
    check("rst_wr_back_id", 64'(WR_BACK_ID), 64'(0));
    check("rst_rd_back_id", 64'(RD_BACK_ID), 64'(0));
    check("rst_wr_len_err", 64'(wr_len_err), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic burst: byte 0x170 -> word 92, i.e. word 12 with 4 address bits.
    wr_burst(32'h170, 8'd3, 2'd0, 32'd0, 4'hF, 8'b0000_1000);
    for (int i = 0; i < 4; i++) rq.push_back(mk(32'(i), i == 3, 2'd0));
    rd_burst(32'h170, 8'd3, 2'd0, 4'b1111, 1'b0);
    check("basic_no_len_err", 64'(err_pulses), 64'(0));

    // Byte strobes, single-beat bursts.
    wr_burst(32'h0, 8'd0, 2'd0, 32'hAABBCCDD, 4'hF, 8'b1);
    wr_burst(32'h0, 8'd0, 2'd0, 32'h11223344, 4'b0101, 8'b1);
    rq.push_back(mk(32'hAA22CC44, 1'b1, 2'd0));
    rd_burst(32'h0, 8'd0, 2'd0, 4'b1111, 1'b0);

    // Wrap-around: words 14,15,0,1 <- 10..13.
    wr_burst(32'h38, 8'd3, 2'd1, 32'd10, 4'hF, 8'b0000_1000);
    rq.push_back(mk(32'd12, 1'b0, 2'd1));
    rq.push_back(mk(32'd13, 1'b1, 2'd1));
    rd_burst(32'h0, 8'd1, 2'd1, 4'b1111, 1'b0);
    rq.push_back(mk(32'd10, 1'b0, 2'd3));
    rq.push_back(mk(32'd11, 1'b1, 2'd3));
    rd_burst(32'h38, 8'd1, 2'd3, 4'b1111, 1'b0);

    // Backpressure: words 12,13,14 = 0,1,10 (14 overwritten by wrap test).
    h0 = rd_hs;
    rq.push_back(mk(32'd0,  1'b0, 2'd2));
    rq.push_back(mk(32'd1,  1'b0, 2'd2));
    rq.push_back(mk(32'd10, 1'b1, 2'd2));
    rd_burst(32'h30, 8'd2, 2'd2, 4'b1001, 1'b0);
    check("bp_handshakes", 64'(rd_hs - h0), 64'(3));

    // LAST early on beat 1 and correct on beat 2: exactly one error pulse,
    // and all three beats are still taken.
    e0 = err_pulses;
    wr_burst(32'h10, 8'd2, 2'd1, 32'h100, 4'hF, 8'b0000_0110);
    repeat (2) @(negedge clk);
    check("len_err_pulses", 64'(err_pulses - e0), 64'(1));

    // Zero strobe on word 5: handshake only, contents unchanged.
    wr_burst(32'h14, 8'd0, 2'd2, 32'hFFFFFFFF, 4'h0, 8'b1);

    // Reset in the middle of a len-7 read (words 4..11).
    rq.push_back(mk(32'h100, 1'b0, 2'd3));
    rq.push_back(mk(32'h101, 1'b0, 2'd3));
    rd_burst(32'h10, 8'd7, 2'd3, 4'b1111, 1'b1);
    check("post_rst_rd_data", 64'(RD_DATA), 64'(0));
    check("post_rst_rd_back_id", 64'(RD_BACK_ID), 64'(0));
    rq.push_back(mk(32'h100, 1'b0, 2'd0));
    rq.push_back(mk(32'h101, 1'b0, 2'd0));
    rq.push_back(mk(32'h102, 1'b1, 2'd0));
    rd_burst(32'h10, 8'd2, 2'd0, 4'b1111, 1'b0);

    repeat (3) @(negedge clk);
    check("no_stray_len_err", 64'(err_pulses), 64'(1));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
